gps_acq_scheduler: RTL and testbench

- Shares one acquisition correlator among the tracking channels of the multichannel GPS engine.
- Grants one requesting channel at a time using round-robin arbitration.
- Sweeps the Doppler-bin × code-phase grid for that channel's PRN, one correlator dwell per grid point, and compares each dwell energy against a threshold.
- Reports hit/miss and grid coordinates back to the channel. Sits between the channel controllers and the shared correlator in the mclk domain.

---
 rtl/gps_acq_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_gps_acq_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_acq_scheduler.sv
// gps_acq_scheduler: round-robin owner of the shared acquisition correlator.
// Sweeps the Doppler x code-phase grid for the granted channel's PRN, one
// dwell per grid point, and reports a threshold hit or the best point seen.
module gps_acq_scheduler #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned DOPP_BINS  = 16,
    parameter int unsigned CODE_STEPS = 2046,
    parameter int unsigned EW         = 24,
    parameter int unsigned PW         = 6
) (
    input  logic                          mclk,
    input  logic                          mclr,
    input  logic [NCH-1:0]                acq_req,
    input  logic [NCH*PW-1:0]             ch_prn,
    input  logic [EW-1:0]                 threshold,
    output logic                          corr_start,
    output logic [PW-1:0]                 corr_prn,
    output logic [$clog2(DOPP_BINS)-1:0]  corr_dopp,
    output logic [$clog2(CODE_STEPS)-1:0] corr_code,
    input  logic                          corr_done,
    input  logic [EW-1:0]                 corr_energy,
    output logic [NCH-1:0]                acq_done,
    output logic                          acq_found,
    output logic [$clog2(DOPP_BINS)-1:0]  found_dopp,
    output logic [$clog2(CODE_STEPS)-1:0] found_code,
    output logic [EW-1:0]                 found_energy,
    output logic                          busy
);
    localparam int unsigned DW = $clog2(DOPP_BINS);
    localparam int unsigned CW = $clog2(CODE_STEPS);
    localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DW-1:0] DOPP_LAST = DW'(DOPP_BINS - 1);
    localparam logic [CW-1:0] CODE_LAST = CW'(CODE_STEPS - 1);
    localparam logic [GW-1:0] RR_RESET  = GW'(NCH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        EVAL   = 3'd4,
        REPORT = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic           abort_q, abort_d;
    logic [EW-1:0]  energy_q, energy_d;
    logic [EW-1:0]  best_energy_q, best_energy_d;
    logic [DW-1:0]  best_dopp_q, best_dopp_d;
    logic [CW-1:0]  best_code_q, best_code_d;
    logic           corr_start_q, corr_start_d;
    logic [PW-1:0]  corr_prn_q, corr_prn_d;
    logic [DW-1:0]  corr_dopp_q, corr_dopp_d;
    logic [CW-1:0]  corr_code_q, corr_code_d;
    logic [NCH-1:0] acq_done_q, acq_done_d;
    logic           acq_found_q, acq_found_d;
    logic [DW-1:0]  found_dopp_q, found_dopp_d;
    logic [CW-1:0]  found_code_q, found_code_d;
    logic [EW-1:0]  found_energy_q, found_energy_d;
    logic           busy_q, busy_d;

    logic           arb_hit;
    logic [GW-1:0]  arb_idx;
    logic [PW-1:0]  arb_prn;
    logic           req_g;

    assign req_g = acq_req[grant_q];

    // Round-robin search: first requester after the last one served.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            if (!arb_hit && acq_req[GW'((32'(rr_q) + i) % NCH)]) begin
                arb_hit = 1'b1;
                arb_idx = GW'((32'(rr_q) + i) % NCH);
            end
        end
    end

    // PRN of the channel the arbiter is about to grant.
    always_comb begin
        arb_prn = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (arb_idx == GW'(k)) arb_prn = ch_prn[k*PW +: PW];
        end
    end

    // Next-state and registered-output logic for the search sequencer.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_d           = rr_q;
        abort_d        = abort_q;
        energy_d       = energy_q;
        best_energy_d  = best_energy_q;
        best_dopp_d    = best_dopp_q;
        best_code_d    = best_code_q;
        corr_start_d   = 1'b0;
        corr_prn_d     = corr_prn_q;
        corr_dopp_d    = corr_dopp_q;
        corr_code_d    = corr_code_q;
        acq_done_d     = '0;
        acq_found_d    = acq_found_q;
        found_dopp_d   = found_dopp_q;
        found_code_d   = found_code_q;
        found_energy_d = found_energy_q;

        case (state_q)
            IDLE: begin
                if (|acq_req) state_d = ARB;
            end
            ARB: begin
                if (arb_hit) begin
                    grant_d       = arb_idx;
                    corr_prn_d    = arb_prn;
                    corr_dopp_d   = '0;
                    corr_code_d   = '0;
                    best_energy_d = '0;
                    best_dopp_d   = '0;
                    best_code_d   = '0;
                    abort_d       = 1'b0;
                    corr_start_d  = 1'b1;
                    state_d       = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (!req_g) begin
                    rr_d    = grant_q;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A withdrawal is remembered so the in-flight dwell is drained first.
                if (!req_g) abort_d = 1'b1;
                if (corr_done) begin
                    if (abort_q || !req_g) begin
                        rr_d    = grant_q;
                        state_d = IDLE;
                    end else begin
                        energy_d = corr_energy;
                        state_d  = EVAL;
                    end
                end
            end
            EVAL: begin
                if (!req_g) begin
                    rr_d    = grant_q;
                    state_d = IDLE;
                end else begin
                    if (energy_q > best_energy_q) begin
                        best_energy_d = energy_q;
                        best_dopp_d   = corr_dopp_q;
                        best_code_d   = corr_code_q;
                    end
                    if (energy_q >= threshold) begin
                        found_dopp_d          = corr_dopp_q;
                        found_code_d          = corr_code_q;
                        found_energy_d        = energy_q;
                        acq_found_d           = 1'b1;
                        acq_done_d[grant_q]   = 1'b1;
                        state_d               = REPORT;
                    end else if (corr_code_q == CODE_LAST) begin
                        corr_code_d = '0;
                        if (corr_dopp_q == DOPP_LAST) begin
                            found_dopp_d        = best_dopp_d;
                            found_code_d        = best_code_d;
                            found_energy_d      = best_energy_d;
                            acq_found_d         = 1'b0;
                            acq_done_d[grant_q] = 1'b1;
                            state_d             = REPORT;
                        end else begin
                            corr_dopp_d  = corr_dopp_q + DW'(1);
                            corr_start_d = 1'b1;
                            state_d      = ISSUE;
                        end
                    end else begin
                        corr_code_d  = corr_code_q + CW'(1);
                        corr_start_d = 1'b1;
                        state_d      = ISSUE;
                    end
                end
            end
            REPORT: begin
                rr_d    = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously by mclr.
    always_ff @(posedge mclk or negedge mclr) begin
        if (!mclr) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            rr_q           <= RR_RESET;
            abort_q        <= 1'b0;
            energy_q       <= '0;
            best_energy_q  <= '0;
            best_dopp_q    <= '0;
            best_code_q    <= '0;
            corr_start_q   <= 1'b0;
            corr_prn_q     <= '0;
            corr_dopp_q    <= '0;
            corr_code_q    <= '0;
            acq_done_q     <= '0;
            acq_found_q    <= 1'b0;
            found_dopp_q   <= '0;
            found_code_q   <= '0;
            found_energy_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_q           <= rr_d;
            abort_q        <= abort_d;
            energy_q       <= energy_d;
            best_energy_q  <= best_energy_d;
            best_dopp_q    <= best_dopp_d;
            best_code_q    <= best_code_d;
            corr_start_q   <= corr_start_d;
            corr_prn_q     <= corr_prn_d;
            corr_dopp_q    <= corr_dopp_d;
            corr_code_q    <= corr_code_d;
            acq_done_q     <= acq_done_d;
            acq_found_q    <= acq_found_d;
            found_dopp_q   <= found_dopp_d;
            found_code_q   <= found_code_d;
            found_energy_q <= found_energy_d;
            busy_q         <= busy_d;
        end
    end

    assign corr_start   = corr_start_q;
    assign corr_prn     = corr_prn_q;
    assign corr_dopp    = corr_dopp_q;
    assign corr_code    = corr_code_q;
    assign acq_done     = acq_done_q;
    assign acq_found    = acq_found_q;
    assign found_dopp   = found_dopp_q;
    assign found_code   = found_code_q;
    assign found_energy = found_energy_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_gps_acq_scheduler.sv
// Bench for gps_acq_scheduler on a reduced 4 x 8 grid with a behavioural
// correlator and a grid-scan reference model of the acquisition result.
module tb_gps_acq_scheduler;
    localparam int unsigned NCH        = 4;
    localparam int unsigned DOPP_BINS  = 4;
    localparam int unsigned CODE_STEPS = 8;
    localparam int unsigned EW         = 24;
    localparam int unsigned PW         = 6;
    localparam int unsigned DW         = $clog2(DOPP_BINS);
    localparam int unsigned CW         = $clog2(CODE_STEPS);
    localparam int unsigned NPTS       = DOPP_BINS * CODE_STEPS;

    logic            mclk, mclr;
    logic [NCH-1:0]  acq_req;
    logic [NCH*PW-1:0] ch_prn;
    logic [EW-1:0]   threshold;
    logic            corr_start;
    logic [PW-1:0]   corr_prn;
    logic [DW-1:0]   corr_dopp;
    logic [CW-1:0]   corr_code;
    logic            corr_done;
    logic [EW-1:0]   corr_energy;
    logic [NCH-1:0]  acq_done;
    logic            acq_found;
    logic [DW-1:0]   found_dopp;
    logic [CW-1:0]   found_code;
    logic [EW-1:0]   found_energy;
    logic            busy;

    int unsigned     etab [NPTS];
    logic [PW-1:0]   prn_of [NCH];
    logic            model_done, man_done;
    logic [EW-1:0]   model_energy, man_energy;
    bit              auto_corr, rand_lat;
    int unsigned     start_total, prn_bad_total, order_bad_total, search_base;
    logic [PW-1:0]   exp_prn;
    int              checks, failures;

    assign ch_prn      = {prn_of[3], prn_of[2], prn_of[1], prn_of[0]};
    assign corr_done   = model_done | man_done;
    assign corr_energy = man_done ? man_energy : model_energy;

    gps_acq_scheduler #(
        .NCH(NCH), .DOPP_BINS(DOPP_BINS), .CODE_STEPS(CODE_STEPS), .EW(EW), .PW(PW)
    ) dut (
        .mclk(mclk), .mclr(mclr), .acq_req(acq_req), .ch_prn(ch_prn),
        .threshold(threshold), .corr_start(corr_start), .corr_prn(corr_prn),
        .corr_dopp(corr_dopp), .corr_code(corr_code), .corr_done(corr_done),
        .corr_energy(corr_energy), .acq_done(acq_done), .acq_found(acq_found),
        .found_dopp(found_dopp), .found_code(found_code),
        .found_energy(found_energy), .busy(busy)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Behavioural correlator: answers each dwell after a short latency and
    // logs every dwell's PRN and grid position.
    initial begin : corr_model
        int cnt;
        int unsigned pt;
        model_done = 1'b0; model_energy = '0; cnt = -1; pt = 0;
        start_total = 0; prn_bad_total = 0; order_bad_total = 0;
        forever begin
            @(negedge mclk);
            model_done = 1'b0;
            if (!mclr || !auto_corr) cnt = -1;
            else if (cnt > 0) cnt--;
            else if (cnt == 0) begin
                model_done   = 1'b1;
                model_energy = EW'(etab[pt]);
                cnt          = -1;
            end
            if (corr_start) begin
                pt = 32'(corr_dopp) * CODE_STEPS + 32'(corr_code);
                if (corr_prn !== exp_prn) prn_bad_total++;
                if (pt != start_total - search_base) order_bad_total++;
                start_total++;
                cnt = rand_lat ? int'($urandom_range(3, 0)) : 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: scan the grid code-inner, Doppler-outer; first point at or
    // above threshold is a hit, otherwise report the first strict maximum.
    task automatic model_search(input int unsigned thr, output bit hit,
                                output int unsigned d, output int unsigned c,
                                output int unsigned e, output int unsigned n);
        int unsigned bd, bc, be;
        bd = 0; bc = 0; be = 0;
        hit = 1'b0; d = 0; c = 0; e = 0; n = NPTS;
        for (int unsigned k = 0; k < NPTS; k++) begin
            if (etab[k] > be) begin
                be = etab[k]; bd = k / CODE_STEPS; bc = k % CODE_STEPS;
            end
            if (etab[k] >= thr) begin
                hit = 1'b1; d = k / CODE_STEPS; c = k % CODE_STEPS; e = etab[k]; n = k + 1;
                return;
            end
        end
        d = bd; c = bc; e = be;
    endtask

    task automatic wait_done(input int budget, output logic [NCH-1:0] dv);
        int n;
        n = 0;
        while (acq_done == '0 && n < budget) begin
            @(negedge mclk);
            n++;
        end
        check("done_wait_bound", 32'(n < budget), 1);
        dv = acq_done;
    endtask

    task automatic arm(input logic [1:0] ch, output int unsigned pb, output int unsigned ob);
        search_base = start_total;
        pb          = prn_bad_total;
        ob          = order_bad_total;
        exp_prn     = prn_of[ch];
    endtask

    task automatic run_search(input logic [1:0] ch, input string tag);
        bit hit;
        int unsigned d, c, e, n, pb, ob;
        logic [NCH-1:0] dv;
        model_search(32'(threshold), hit, d, c, e, n);
        arm(ch, pb, ob);
        acq_req[ch] = 1'b1;
        @(negedge mclk);
        wait_done(2000, dv);
        acq_req[ch] = 1'b0;
        check({tag, "_done"},   32'(dv), 32'(1) << ch);
        check({tag, "_found"},  32'(acq_found), 32'(hit));
        check({tag, "_dopp"},   32'(found_dopp), d);
        check({tag, "_code"},   32'(found_code), c);
        check({tag, "_energy"}, 32'(found_energy), e);
        check({tag, "_dwells"}, start_total - search_base, n);
        check({tag, "_prn"},    prn_bad_total - pb, 0);
        check({tag, "_order"},  order_bad_total - ob, 0);
        @(negedge mclk);
    endtask

    // Serve an already-raised request expected to go to ch; threshold is 0.
    task automatic serve(input logic [1:0] ch, input bit raise0, input string tag);
        int unsigned pb, ob;
        int n;
        logic [NCH-1:0] dv;
        arm(ch, pb, ob);
        @(negedge mclk);
        if (raise0) begin
            n = 0;
            while (start_total == search_base && n < 50) begin
                @(negedge mclk);
                n++;
            end
            acq_req[0] = 1'b1;
        end
        wait_done(300, dv);
        acq_req[ch] = 1'b0;
        check({tag, "_grant"},  32'(dv), 32'(1) << ch);
        check({tag, "_found"},  32'(acq_found), 1);
        check({tag, "_pos"},    {16'(found_dopp), 16'(found_code)}, 0);
        check({tag, "_energy"}, 32'(found_energy), etab[0]);
        check({tag, "_dwells"}, start_total - search_base, 1);
        check({tag, "_prn"},    prn_bad_total - pb, 0);
        @(negedge mclk);
    endtask

    task automatic reset_dut();
        mclr = 1'b0;
        @(negedge mclk);
        @(negedge mclk);
        mclr = 1'b1;
        @(negedge mclk);
    endtask

    initial begin : stim
        int sc, ad;
        checks = 0; failures = 0;
        mclr = 1'b1; acq_req = '0; threshold = '0;
        man_done = 1'b0; man_energy = '0;
        auto_corr = 1'b1; rand_lat = 1'b1;
        search_base = 0; exp_prn = '0;
        prn_of[0] = 6'd7; prn_of[1] = 6'd12; prn_of[2] = 6'd33; prn_of[3] = 6'd63;
        for (int i = 0; i < int'(NPTS); i++) etab[i] = 0;

        // Reset state.
        #1 mclr = 1'b0;
        @(negedge mclk);
        @(negedge mclk);
        check("rst_start", 32'(corr_start), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(acq_done), 0);
        check("rst_found", {8'(acq_found), 8'(found_dopp), 16'(found_code)}, 0);
        check("rst_corr",  {8'(corr_prn), 8'(corr_dopp), 16'(corr_code)}, 0);
        mclr = 1'b1;
        @(negedge mclk);

        // Single hit at (2,5).
        threshold = 24'd4000;
        etab[2*CODE_STEPS + 5] = 5000;
        run_search(2'd0, "hit");

        // Full miss; two equal maxima, the first one must be kept.
        for (int i = 0; i < int'(NPTS); i++) etab[i] = $urandom_range(299, 0);
        etab[1*CODE_STEPS + 7] = 300;
        etab[3*CODE_STEPS + 2] = 300;
        run_search(2'd0, "miss");

        // Randomized grids, thresholds and channels.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < int'(NPTS); i++) etab[i] = $urandom_range(6000, 0);
            threshold = (t % 3 == 2) ? 24'hFFFFFF : EW'($urandom_range(7000, 4000));
            run_search(2'($urandom_range(3, 0)), "rand");
        end

        // Round robin from reset: 0, 1, 3, then ch0 re-raised during ch3.
        reset_dut();
        threshold = '0;
        etab[0] = 123;
        acq_req = 4'b1011;
        serve(2'd0, 1'b0, "rr0");
        serve(2'd1, 1'b0, "rr1");
        serve(2'd3, 1'b1, "rr3");
        serve(2'd0, 1'b0, "rr0b");

        // Stray corr_done in ARB/ISSUE is ignored; threshold 0 hits at (0,0).
        auto_corr = 1'b0;
        exp_prn = prn_of[1];
        acq_req = 4'b0010;
        @(negedge mclk);
        check("t3_arb_start", 32'(corr_start), 0);
        man_done = 1'b1; man_energy = 24'd55;
        @(negedge mclk);
        check("t3_issue_start", 32'(corr_start), 1);
        @(negedge mclk);
        man_done = 1'b0;
        repeat (2) begin
            @(negedge mclk);
            check("t3_wait_busy", {16'(busy), 16'(acq_done)}, 32'h0001_0000);
        end
        man_done = 1'b1; man_energy = 24'd77;
        @(negedge mclk);
        man_done = 1'b0;
        check("t3_eval_done", 32'(acq_done), 0);
        @(negedge mclk);
        check("t3_report_done", 32'(acq_done), 32'h2);
        check("t3_report_res", {8'(acq_found), 8'(found_dopp), 16'(found_code)}, 32'h0100_0000);
        check("t3_report_energy", 32'(found_energy), 77);
        acq_req = '0;
        @(negedge mclk);
        check("t3_idle_busy", 32'(busy), 0);

        // Latency: request -> start +2, done -> next start +2, done after EVAL.
        threshold = 24'hFFFFFF;
        exp_prn = prn_of[2];
        acq_req = 4'b0100;
        @(negedge mclk);
        check("t6_arb_start", 32'(corr_start), 0);
        @(negedge mclk);
        check("t6_issue_start", 32'(corr_start), 1);
        check("t6_issue_prn", 32'(corr_prn), 32'(prn_of[2]));
        @(negedge mclk);
        man_done = 1'b1; man_energy = 24'd5;
        @(negedge mclk);
        man_done = 1'b0;
        check("t6_eval_start", 32'(corr_start), 0);
        @(negedge mclk);
        check("t6_next_start", {16'(corr_start), 8'(corr_dopp), 8'(corr_code)}, 32'h0001_0001);
        threshold = '0;
        @(negedge mclk);
        man_done = 1'b1; man_energy = 24'd9;
        @(negedge mclk);
        man_done = 1'b0;
        check("t6_eval_done", 32'(acq_done), 0);
        @(negedge mclk);
        check("t6_report_done", 32'(acq_done), 32'h4);
        check("t6_report_res", {8'(acq_found), 8'(found_dopp), 16'(found_code)}, 32'h0100_0001);
        check("t6_report_energy", 32'(found_energy), 9);
        acq_req = '0;
        @(negedge mclk);

        // Abort: drop the granted request during WAIT.
        threshold = 24'hFFFFFF;
        acq_req = 4'b0010;
        @(negedge mclk);
        @(negedge mclk);
        check("t4_issue_start", 32'(corr_start), 1);
        @(negedge mclk);
        acq_req = '0;
        @(negedge mclk);
        check("t4_wait_busy", {16'(busy), 16'(acq_done)}, 32'h0001_0000);
        man_done = 1'b1; man_energy = 24'd4;
        @(negedge mclk);
        man_done = 1'b0;
        check("t4_busy_fall", {16'(busy), 16'(acq_done)}, 0);
        sc = 0; ad = 0;
        repeat (5) begin
            @(negedge mclk);
            if (corr_start) sc++;
            if (acq_done != '0) ad++;
        end
        check("t4_no_start", sc, 0);
        check("t4_no_done", ad, 0);
        // The aborted channel still moves the round-robin pointer.
        auto_corr = 1'b1; threshold = '0;
        acq_req = 4'b0110;
        serve(2'd2, 1'b0, "t4_rr2");
        serve(2'd1, 1'b0, "t4_rr1");

        // Asynchronous reset between clock edges in WAIT.
        auto_corr = 1'b0; threshold = 24'hFFFFFF;
        acq_req = 4'b0010;
        repeat (3) @(negedge mclk);
        check("t5_wait_busy", 32'(busy), 1);
        #2 mclr = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_start", 32'(corr_start), 0);
        check("t5_found", {8'(acq_found), 8'(found_dopp), 16'(found_code)}, 0);
        check("t5_energy", 32'(found_energy), 0);
        check("t5_prn", 32'(corr_prn), 0);
        acq_req = '0;
        @(negedge mclk);
        mclr = 1'b1;
        @(negedge mclk);
        auto_corr = 1'b1; threshold = '0;
        acq_req = 4'b0100;
        serve(2'd2, 1'b0, "t5_ch2");
        acq_req = 4'b0101;
        serve(2'd0, 1'b0, "t5_ch0");
        serve(2'd2, 1'b0, "t5_ch2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
